// File: rtl/bpu_pkg.sv
// bpu_pkg
//   Definitions shared by the next-PC generator, the IF stage and the backend
//   update path of the branch prediction unit.
//   RESET_PC   : first fetch address after reset
//   IDX_W      : btb index width (log2 of btb entry count)
//   pred_rec_t : one {pc, prediction} record as buffered for instruction fetch
package bpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          IDX_W    = 5;

  typedef struct packed {
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
    logic [IDX_W-1:0] idx;
    logic             hit;
  } pred_rec_t;

endpackage

// File: rtl/bpu_pc_gen_pred_fifo.sv
// pred_fifo
//   Registered FIFO of prediction records between the next-PC generator and
//   the instruction-fetch stage.
//   clk, rst    : clock, asynchronous active-high reset
//   flush_i     : synchronous clear (wins over push and pop)
//   push_i      : write push_rec_i at the tail
//   push_rec_i  : record to write
//   pop_i       : consumer takes the head (ignored while empty)
//   head_o      : head record
//   count_o     : number of stored records, used by the producer's credit check
module pred_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  pred_rec_t        push_rec_i,
  input  logic             pop_i,
  output pred_rec_t        head_o,
  output logic [CNT_W-1:0] count_o
);

  pred_rec_t        mem_q [DEPTH];
  pred_rec_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_rec_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    end
  end

  // Storage is cleared on reset so every output reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The producer's credit check must make a push into a full FIFO impossible.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && !pop_ok && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/bpu_pc_gen.sv
// bpu_pc_gen
//   Next-PC generator sitting directly in front of the btb. Issues one fetch
//   PC per cycle, folds the btb's prediction for last cycle's PC into the
//   next fetch with no bubble, and queues {pc, prediction} records for IF.
//   clk, reset       : clock, asynchronous active-high reset
//   fetch_pc/en      : address issued to btb and instruction fetch
//   btb_*            : btb result for the PC issued in the previous cycle
//   redirect_valid/pc: backend flush and restart address
//   out_*            : FIFO head record with valid/ready handshake
module bpu_pc_gen
  import bpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = bpu_pkg::RESET_PC,
  parameter int          IDX_W    = bpu_pkg::IDX_W,
  parameter int          Q_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      fetch_pc,
  output logic             fetch_en,
  input  logic [31:0]      btb_target,
  input  logic             btb_taken,
  input  logic [IDX_W-1:0] btb_index,
  input  logic             btb_pre_en,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic             out_pred_taken,
  output logic [31:0]      out_pred_target,
  output logic [IDX_W-1:0] out_btb_index,
  output logic             out_btb_hit
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_pc_q, s1_pc_d;
  logic             s1_taken;
  logic [CNT_W:0]   inflight;
  logic             credit_ok;
  logic             push;
  pred_rec_t        push_rec;
  pred_rec_t        head;
  logic [CNT_W-1:0] fifo_count;

  // Credit counts the request still waiting for its btb result, because it
  // will push next cycle whether or not IF pops. A same-cycle pop is not
  // counted, which keeps the fetch_en path short.
  always_comb begin
    s1_taken  = s1_valid_q && btb_pre_en && btb_taken;
    inflight  = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_q);
    credit_ok = inflight < (CNT_W + 1)'(Q_DEPTH);
    fetch_en  = !reset && (redirect_valid || credit_ok);

    if (reset) begin
      fetch_pc = RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc = redirect_pc;
    end else if (s1_taken) begin
      fetch_pc = btb_target;
    end else begin
      fetch_pc = pc_q;
    end

    // When stalled, the mux choice is still banked into pc so a taken
    // target resolved during the stall becomes the first fetch afterwards.
    s1_valid_d = fetch_en;
    s1_pc_d    = s1_pc_q;
    pc_d       = pc_q;
    if (fetch_en) begin
      s1_pc_d = fetch_pc;
      pc_d    = fetch_pc + 32'd4;
    end else begin
      pc_d = fetch_pc;
    end

    push            = s1_valid_q && !redirect_valid;
    push_rec.pc     = s1_pc_q;
    push_rec.taken  = s1_taken;
    push_rec.target = btb_pre_en ? btb_target : 32'd0;
    push_rec.idx    = btb_index;
    push_rec.hit    = btb_pre_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
    end
  end

  pred_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_rec_i (push_rec),
    .pop_i      (out_valid && out_ready),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  assign out_valid       = (fifo_count != '0);
  assign out_pc          = head.pc;
  assign out_pred_taken  = head.taken;
  assign out_pred_target = head.target;
  assign out_btb_index   = head.idx;
  assign out_btb_hit     = head.hit;

endmodule
